ats_token_bucket_gate: RTL

ATS_TOKEN_BUCKET_GATE -- requirements
Module: ats_token_bucket_gate

---
 rtl/ats_token_bucket_gate.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ats_token_bucket_gate.sv
// ats_token_bucket_gate
// Admits one frame at a time from an AXI-Stream source. Each frame's L1 length
// arrives on a side channel and is accepted only when the token bucket holds
// enough credit. Credit is then deducted and the data beats pass through with
// zero latency until tlast.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   s_axis_*                   frame data in (stalled while waiting for credit)
//   s_axis_frame_length_*      frame length in bytes, one per frame
//   m_axis_*                   gated frame data out (combinational pass-through)
//   cfg_cir                    refill rate, bytes/cycle, FRAC_BITS fractional bits
//   cfg_cbs                    bucket capacity in bytes
//   tokens                     current bucket level, fixed point
//   stat_frames                accepted lengths      (ATS_TOKEN_GATE_STATS_EN only)
//   stat_stall_cycles          credit-starved cycles (ATS_TOKEN_GATE_STATS_EN only)
//
// Optional feature macro: ATS_TOKEN_GATE_STATS_EN
module ats_token_bucket_gate #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
  parameter int unsigned C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int unsigned FRAME_LENGTH_WIDTH = 16,
  parameter int unsigned FRAC_BITS          = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [FRAME_LENGTH_WIDTH-1:0]         s_axis_frame_length_tdata,
  input  logic                                  s_axis_frame_length_tvalid,
  output logic                                  s_axis_frame_length_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  input  logic [FRAME_LENGTH_WIDTH+FRAC_BITS-1:0] cfg_cir,
  input  logic [FRAME_LENGTH_WIDTH-1:0]         cfg_cbs,
  output logic [FRAME_LENGTH_WIDTH+FRAC_BITS:0] tokens
`ifdef ATS_TOKEN_GATE_STATS_EN
  ,
  output logic [31:0]                           stat_frames,
  output logic [31:0]                           stat_stall_cycles
`endif
);

  localparam int unsigned TW = FRAME_LENGTH_WIDTH + FRAC_BITS + 1;
  localparam int unsigned SW = TW + 1;

  typedef enum logic {
    WAIT_LEN = 1'b0,
    PASS     = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] cap;
  logic [TW-1:0] len;
  logic [SW-1:0] sum;
  logic [TW-1:0] refill;
  logic [TW-1:0] after_len;
  logic          eligible;
  logic          len_hs;
  logic          last_hs;

  // Fixed-point capacity and frame cost; the extra token bit keeps the shift lossless.
  assign cap = TW'(cfg_cbs) << FRAC_BITS;
  assign len = TW'(s_axis_frame_length_tdata) << FRAC_BITS;

  // Saturating refill computed one bit wider so tokens+cir cannot wrap.
  assign sum    = SW'(tokens) + SW'(cfg_cir);
  assign refill = (sum > SW'(cap)) ? cap : TW'(sum);

  // A full bucket always admits, so a frame longer than the bucket cannot deadlock.
  assign eligible  = (tokens >= len) || (tokens == cap);
  assign after_len = (refill >= len) ? (refill - len) : '0;

  // Handshake-facing outputs are combinational so the gate adds no latency.
  assign s_axis_frame_length_tready = rstn && (state == WAIT_LEN) &&
                                      s_axis_frame_length_tvalid && eligible;
  assign s_axis_tready = (state == PASS) && m_axis_tready;
  assign m_axis_tvalid = (state == PASS) && s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign len_hs  = s_axis_frame_length_tvalid && s_axis_frame_length_tready;
  assign last_hs = s_axis_tvalid && s_axis_tready && s_axis_tlast;

  // Gate FSM and bucket level; refill happens in every state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= WAIT_LEN;
      tokens <= '0;
    end else begin
      case (state)
        WAIT_LEN: begin
          if (len_hs) begin
            tokens <= after_len;
            state  <= PASS;
          end else begin
            tokens <= refill;
          end
        end
        PASS: begin
          tokens <= refill;
          if (last_hs) state <= WAIT_LEN;
        end
        default: begin
          tokens <= refill;
          state  <= WAIT_LEN;
        end
      endcase
    end
  end

`ifdef ATS_TOKEN_GATE_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_frames       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (len_hs) stat_frames <= stat_frames + 32'd1;
      if ((state == WAIT_LEN) && s_axis_frame_length_tvalid && !eligible)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
